// File: rtl/wide_add_sub_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wide_add_sub_seq_pkg                                             |
// | Brief    : Shared FSM encodings, opcodes and width helper.                  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package wide_add_sub_seq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_RUN  = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_w(input int n, input int k);
    return n * k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wide_add_sub_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wide_add_sub_seq_if                                              |
// | Brief    : Request/result bundle between a requester and the adder.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wide_add_sub_seq_if
  import wide_add_sub_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
);
  localparam int W = calc_w(N, K);

  logic         start_in;
  logic         opcode_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] result_out;
  logic         carry_or_borrow_out;
  logic         overflow_out;

  modport master (
    output start_in, opcode_in, a_in, b_in,
    input  busy_out, done_out, result_out, carry_or_borrow_out, overflow_out
  );

  modport slave (
    input  start_in, opcode_in, a_in, b_in,
    output busy_out, done_out, result_out, carry_or_borrow_out, overflow_out
  );

endinterface
`default_nettype wire

// File: rtl/wide_add_sub_seq_add_sub_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : add_sub_slice                                                    |
// | Brief    : Combinational N-bit add/sub slice with carry in/out.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module add_sub_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  // Subtraction is a + ~b + 1; the +1 arrives as carry_in on the first slice.
  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b ^ {N{op}}} + {{N{1'b0}}, carry_in};
  end

endmodule
`default_nettype wire

// File: rtl/wide_add_sub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wide_add_sub_seq                                                 |
// | Brief    : Multi-cycle W=N*K add/sub, one N-bit slice per clock, LSB first. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module wide_add_sub_seq
  import wide_add_sub_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                rst,
  wide_add_sub_seq_if.slave   bus
);

  localparam int W  = calc_w(N, K);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_op;
  logic           r_carry;
  logic           r_done;
  logic           r_cout;
  logic           r_ovf;

  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_ovf;

  // Operands shift right each slice, so the active slice is always the low N bits.
  add_sub_slice #(.N(N)) u_slice (
    .a         (r_a[N-1:0]),
    .b         (r_b[N-1:0]),
    .op        (r_op),
    .carry_in  (r_carry),
    .sum       (w_sum),
    .carry_out (w_cout)
  );

  assign w_last = (r_idx == IW'(K - 1));

  // On the last slice the low bits hold the operands' top slice, so its MSBs are the W-bit MSBs.
  assign w_ovf = (r_a[N-1] == (r_b[N-1] ^ r_op)) && (w_sum[N-1] != r_a[N-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_in) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_op    <= bus.opcode_in;
            r_carry <= (bus.opcode_in == OP_SUB);
            r_idx   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> N;
          r_b     <= r_b >> N;
          r_res   <= {w_sum, r_res[W-1:N]};
          r_carry <= w_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_idx   <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_out            = (r_state == S_RUN);
  assign bus.done_out            = r_done;
  assign bus.result_out          = r_res;
  assign bus.carry_or_borrow_out = r_cout;
  assign bus.overflow_out        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wide_add_sub_seq                                              |
// | Brief    : Self-checking bench for wide_add_sub_seq against a W-bit model.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wide_add_sub_seq;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wide_add_sub_seq_if #(.N(N), .K(K)) bus ();

  wide_add_sub_seq #(.N(N), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Whole-word arithmetic: unsigned for result/carry, signed range check for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                output logic [W-1:0] res, output logic c, output logic v);
    longint ua, ub, sa, sb, sr, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    sa  = a[W-1] ? ua - (lim << 1) : ua;
    sb  = b[W-1] ? ub - (lim << 1) : ub;
    if (op == 1'b0) begin
      res = W'(ua + ub);
      c   = (ua + ub) >= (lim << 1);
      sr  = sa + sb;
    end else begin
      res = W'(ua - ub);
      c   = (ua >= ub);
      sr  = sa - sb;
    end
    v = (sr > lim - 1) || (sr < -lim);
  endfunction

  task automatic idle(input int n);
    bus.start_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Starts at a negedge, returns at the negedge where done_out is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input int glitch_at,
                        output logic [W-1:0] res, output logic c, output logic v,
                        output int lat, output int busy_cnt, output bit to);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.opcode_in = op;
    bus.start_in  = 1'b1;
    lat = 0; busy_cnt = 0; to = 1'b0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus.start_in  = 1'b0;
        bus.a_in      = W'($urandom);
        bus.b_in      = W'($urandom);
        bus.opcode_in = 1'($urandom);
      end
      if (glitch_at != 0 && lat == glitch_at) bus.start_in = 1'b1;
      if (glitch_at != 0 && lat == glitch_at + 1) bus.start_in = 1'b0;
      if (bus.busy_out) busy_cnt++;
      if (bus.done_out) break;
      if (lat > 20) begin
        to = 1'b1;
        break;
      end
    end
    bus.start_in = 1'b0;
    res = bus.result_out;
    c   = bus.carry_or_borrow_out;
    v   = bus.overflow_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_in = 1'b0; bus.opcode_in = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_out); end
    checks++; if (bus.result_out !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_out); end
    checks++; if (bus.carry_or_borrow_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", bus.carry_or_borrow_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow_out); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb [6] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
    logic         top[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] tr [6] = '{16'h2233, 16'h0000, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF};
    logic         tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         tv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] res;
    logic c, v;
    int lat, bc;
    bit to;
    for (int i = 0; i < 6; i++) begin
      idle(2);
      run_op(ta[i], tb[i], top[i], 0, res, c, v, lat, bc, to);
      checks++; if (to || lat !== K + 1) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, K + 1); end
      checks++; if (bc !== K) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, K); end
      checks++; if (res !== tr[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, tr[i]); end
      checks++; if (c !== tc[i]) begin errors++; $display("FAIL dir%0d_carry got=%b exp=%b", i, c, tc[i]); end
      checks++; if (v !== tv[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, v, tv[i]); end
      @(negedge clk);
      checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done_out); end
      checks++; if (bus.result_out !== tr[i]) begin errors++; $display("FAIL dir%0d_result_hold got=%h exp=%h", i, bus.result_out, tr[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, er;
    logic op, c, v, ec, ev;
    int lat, bc;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 1'($urandom);
      if (i % 8 == 0) a[W-1] = b[W-1] ^ op;
      model(a, b, op, er, ec, ev);
      idle(1 + (i % 3));
      run_op(a, b, op, 0, res, c, v, lat, bc, to);
      checks++;
      if (to || res !== er || c !== ec || v !== ev || lat !== K + 1) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h op=%b got res=%h c=%b v=%b lat=%0d exp res=%h c=%b v=%b lat=%0d",
                 i, a, b, op, res, c, v, lat, er, ec, ev, K + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] res;
    logic c, v;
    int lat, bc, extra;
    bit to;
    idle(2);
    run_op(16'h1234, 16'h0FFF, 1'b0, 2, res, c, v, lat, bc, to);
    checks++; if (to || lat !== K + 1) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, K + 1); end
    checks++; if (res !== 16'h2233) begin errors++; $display("FAIL ignore_result got=%h exp=2233", res); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done_out || bus.busy_out) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, res, er;
    logic op, c, v, ec, ev;
    int lat, bc;
    bit to;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 1'(i);
      model(a, b, op, er, ec, ev);
      run_op(a, b, op, 0, res, c, v, lat, bc, to);
      checks++; if (to || lat !== K + 1) begin errors++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, K + 1); end
      checks++;
      if (res !== er || c !== ec || v !== ev) begin
        errors++;
        $display("FAIL b2b%0d_value got res=%h c=%b v=%b exp res=%h c=%b v=%b", i, res, c, v, er, ec, ev);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] res;
    logic c, v;
    int lat, bc, seen;
    bit to;
    idle(2);
    bus.a_in = 16'h1234; bus.b_in = 16'h0FFF; bus.opcode_in = 1'b0; bus.start_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done_out); end
    checks++; if (bus.result_out !== '0) begin errors++; $display("FAIL midrst_result got=%h exp=0", bus.result_out); end
    checks++; if (bus.carry_or_borrow_out !== 1'b0 || bus.overflow_out !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got c=%b v=%b exp 0 0", bus.carry_or_borrow_out, bus.overflow_out);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done_out) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    run_op(16'h0001, 16'h0001, 1'b0, 0, res, c, v, lat, bc, to);
    checks++; if (to || res !== 16'h0002) begin errors++; $display("FAIL midrst_next_result got=%h exp=0002", res); end
    checks++; if (lat !== K + 1) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=%0d", lat, K + 1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wide_add_sub_seq.md
Name: wide_add_sub_seq

Overview:
Multi-cycle wide adder/subtractor that processes K slices of N bits, least-significant slice first, one slice per clock. The carry is chained between slices through a register. It sits in front of the N-bit add/sub datapath: it sequences operand slices into a slice adder and collects the slice results into a W = N*K bit result. Use it where a full-width single-cycle adder would break timing or cost too much area.

Parameters:
N, 4, slice width in bits (>=1)
K, 4, number of slices (>=2); full operand width W = N*K

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start_in  input  1  request a new operation; sampled only in IDLE
opcode_in  input  1  0 = a+b, 1 = a-b; latched with operands
a_in  input  W  operand A; latched when start is accepted
b_in  input  W  operand B; latched when start is accepted
busy_out  output  1  high while slices are being processed
done_out  output  1  one-cycle pulse: result and flags valid
result_out  output  W  sum/difference; holds until the next accepted start
carry_or_borrow_out  output  1  carry out of MSB slice; for subtract, 1 = no borrow (A >= B unsigned)
overflow_out  output  1  two's-complement signed overflow of the W-bit operation

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, slice index 0, and busy_out, done_out, result_out, carry_or_borrow_out, overflow_out all 0. Operand registers are cleared.
- FSM states: IDLE, RUN.
  - IDLE + start_in=1 at edge E0: latch a_in, b_in, opcode_in; carry register <= opcode_in; index <= 0; go to RUN; busy_out=1 after E0.
  - RUN at edge E(i+1), i=0..K-1: compute slice i as a[i] + (b[i] XOR {N{op}}) + carry_reg; write the N-bit sum into result slice i; carry_reg <= slice carry-out; index++.
  - At E_K (last slice): go to IDLE; busy_out=0; done_out=1 for exactly one cycle; carry_or_borrow_out = MSB-slice carry; overflow_out set.
- Overflow: overflow_out = (a[W-1] == beff[W-1]) && (res[W-1] != a[W-1]), where beff = b XOR {W{op}}. Equivalently, carry into the MSB XOR carry out of the MSB.
- Latency and throughput: done_out is seen in the cycle after E_K, i.e. K+1 edges after start is sampled. A start asserted in the done_out cycle is accepted (state is already IDLE), so throughput is one operation per K+1 cycles.
- start_in while busy: ignored; latched operands and progress are unaffected.
- result_out, carry_or_borrow_out and overflow_out update slice-by-slice or at the end only. They are guaranteed only while done_out=1 and until the next accepted start.
- Flags: carry and overflow hold their last values until the next done. On an accepted start they are cleared to 0.
- Reset mid-operation: abort immediately; no done_out pulse; all outputs return to reset values. The next start behaves normally.
- Arithmetic wraps modulo 2^W; there is no saturation.

Decomposition:
- Shared package: state enum (IDLE, RUN), OP_ADD=1'b0, OP_SUB=1'b1, and the width helper W = N*K.
- Natural sub-module: add_sub_slice, a combinational N-bit unit with inputs a, b, op, carry_in and outputs sum, carry_out. The top level owns the FSM, slice index, operand/result registers and carry register.
- No other hierarchy is needed.

Test Plan:
- Directed add (N=4, K=4): A=0x1234, B=0x0FFF, op=0 -> done_out exactly 5 cycles after start; result 0x2233, carry 0, overflow 0; busy_out high for 4 cycles.
- Full carry ripple: A=0xFFFF, B=0x0001, op=0 -> result 0x0000, carry 1, overflow 0. Checks that the inter-slice carry propagates through all 4 slices.
- Subtract with borrow: A=0x0005, B=0x0007, op=1 -> result 0xFFFE, carry 0, overflow 0. Then A=0x0007, B=0x0005 -> result 0x0002, carry 1.
- Signed overflow: A=0x7FFF + B=0x0001 -> result 0x8000, overflow 1, carry 0. Then A=0x8000 - B=0x0001 -> result 0x7FFF, overflow 1, carry 1.
- Handshake:
  - start_in pulsed with different operands on cycle 2 of an operation -> ignored, first result unchanged.
  - start asserted in the done_out cycle -> accepted, second done 5 cycles later.
- Reset mid-op: rst=1 after slice 2 of A=0x1234+B=0x0FFF -> no done_out, all outputs 0. The next op 0x0001+0x0001 -> 0x0002.
